// File: rtl/idu_rf_scoreboard.sv
// RAW/WAW hazard scoreboard gating the ID->EX register: per-GPR and CSR
// in-flight write counters, issue increments and WB commit decrements.

module idu_rf_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             uf
);
  // Same-cycle inc and dec cancel, so neither overflow nor underflow can trip.
  assign uf = dec && !inc && (cnt == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                            cnt <= '0;
    else if (inc && !dec)                 cnt <= cnt + 1'b1;
    else if (dec && !inc && cnt != '0)    cnt <= cnt - 1'b1;
  end
endmodule

module idu_rf_scoreboard #(
  parameter int NREG  = 16,
  parameter int CNT_W = 2,
  localparam int RW   = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [RW-1:0] i_rs1,
  input  logic          i_rs1_used,
  input  logic [RW-1:0] i_rs2,
  input  logic          i_rs2_used,
  input  logic [RW-1:0] i_rd,
  input  logic          i_wen,
  input  logic          i_csr_rd,
  input  logic          i_csr_wen,
  input  logic          i_serialize,
  input  logic          i_issue,
  input  logic          i_wb_valid,
  input  logic [RW-1:0] i_wb_rd,
  input  logic          i_wb_wen,
  input  logic          i_wb_csr_wen,
  output logic          o_rf_valid,
  output logic          o_busy_any,
  output logic          o_err
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] cnt [NREG];
  logic             uf  [NREG];
  logic [CNT_W-1:0] cnt_csr;
  logic             uf_csr;
  logic             accept;
  logic             any_uf;
  logic             err_q;

  assign accept = i_issue && o_rf_valid;

  // x0 has no counter: it reads as permanently idle.
  assign cnt[0] = '0;
  assign uf[0]  = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_gpr
    localparam logic [RW-1:0] IDX = RW'(r);
    idu_rf_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (accept && i_wen && (i_rd == IDX)),
      .dec   (i_wb_valid && i_wb_wen && (i_wb_rd == IDX)),
      .cnt   (cnt[r]),
      .uf    (uf[r])
    );
  end

  idu_rf_cnt #(.CNT_W(CNT_W)) u_csr (
    .clock (clock),
    .reset (reset),
    .inc   (accept && i_csr_wen),
    .dec   (i_wb_valid && i_wb_csr_wen),
    .cnt   (cnt_csr),
    .uf    (uf_csr)
  );

  always_comb begin
    o_busy_any = (cnt_csr != '0);
    any_uf     = uf_csr;
    for (int r = 0; r < NREG; r++) begin
      o_busy_any = o_busy_any || (cnt[r] != '0);
      any_uf     = any_uf || uf[r];
    end
  end

  always_comb begin
    o_rf_valid = 1'b1;
    if (i_rs1_used && cnt[i_rs1] != '0)     o_rf_valid = 1'b0;
    if (i_rs2_used && cnt[i_rs2] != '0)     o_rf_valid = 1'b0;
    if (i_csr_rd && cnt_csr != '0)          o_rf_valid = 1'b0;
    if (i_serialize && o_busy_any)          o_rf_valid = 1'b0;
    if (i_wen && i_rd != '0 && cnt[i_rd] == MAX) o_rf_valid = 1'b0;
    if (i_csr_wen && cnt_csr == MAX)        o_rf_valid = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                   err_q <= 1'b0;
    else if ((i_issue && !o_rf_valid) || any_uf) err_q <= 1'b1;
  end

  assign o_err = err_q;
endmodule
